nco_phase_acc: RTL and testbench

//  Numerically controlled phase accumulator producing the 16-bit sawtooth phase

---
 rtl/nco_phase_acc.sv | 78 +++++++
 tb/tb_nco_phase_acc.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_phase_acc.sv
// Phase accumulator for the NCO: accumulates the active tuning word on each accepted
// sample and streams the offset 16-bit sawtooth phase over valid/ready.
module nco_phase_acc #(
  parameter int unsigned ACC_W          = 32,
  parameter int unsigned UPDATE_ON_WRAP = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [ACC_W-1:0] i_ftw,
  input  logic             i_ftw_valid,
  output logic             o_ftw_ready,
  input  logic [15:0]      i_poff,
  input  logic             i_sync,
  output logic [15:0]      o_saw,
  output logic             o_wrap,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam bit WRAP_MODE = (UPDATE_ON_WRAP != 0);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw_act;
  logic [ACC_W-1:0] ftw_pend;
  logic             pend_valid;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             step;
  logic             ftw_take;
  logic             ftw_apply;

  assign o_ftw_ready = !pend_valid && !i_rst;

  always_comb begin
    step      = i_en && (!o_valid || i_ready);
    sum       = {1'b0, acc} + {1'b0, ftw_act};
    carry     = sum[ACC_W];
    ftw_take  = i_ftw_valid && o_ftw_ready;
    // Only a word already pending at this edge may be applied; a word captured now waits.
    ftw_apply = pend_valid && (i_sync || (step && (!WRAP_MODE || carry)));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc        <= '0;
      ftw_act    <= '0;
      ftw_pend   <= '0;
      pend_valid <= 1'b0;
      o_saw      <= '0;
      o_wrap     <= 1'b0;
      o_valid    <= 1'b0;
    end else begin
      if (step) begin
        o_saw   <= acc[ACC_W-1 -: 16] + i_poff;
        o_wrap  <= carry && !i_sync;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      if (i_sync) begin
        acc <= '0;
      end else if (step) begin
        acc <= sum[ACC_W-1:0];
      end

      if (ftw_apply) begin
        ftw_act    <= ftw_pend;
        pend_valid <= 1'b0;
      end else if (ftw_take) begin
        ftw_pend   <= i_ftw;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nco_phase_acc.sv
// Bench for nco_phase_acc: runs a wrap-deferred (index 1) and an immediate-update
// (index 0) instance side by side against directed spec sequences and a reference model.
module tb_nco_phase_acc;

  localparam int unsigned ACC_W = 32;
  localparam longint unsigned ACC_MOD = 64'h1_0000_0000;

  logic             clk;
  logic             rst;
  logic             en;
  logic [ACC_W-1:0] ftw;
  logic             ftw_valid;
  logic [15:0]      poff;
  logic             sync;
  logic             ready;

  logic [15:0] saw    [2];
  logic        wrap   [2];
  logic        valid  [2];
  logic        fready [2];

  int errors = 0;
  int checks = 0;

  // Reference model state, per instance: phase, active/pending word, output slot.
  longint unsigned m_acc  [2];
  longint unsigned m_ftw  [2];
  longint unsigned m_pend [2];
  bit              m_pv   [2];
  logic [15:0]     m_saw  [2];
  bit              m_wrap [2];
  bit              m_val  [2];

  nco_phase_acc #(.ACC_W(ACC_W), .UPDATE_ON_WRAP(0)) dut_n (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_ftw(ftw), .i_ftw_valid(ftw_valid),
    .o_ftw_ready(fready[0]), .i_poff(poff), .i_sync(sync), .o_saw(saw[0]),
    .o_wrap(wrap[0]), .o_valid(valid[0]), .i_ready(ready)
  );

  nco_phase_acc #(.ACC_W(ACC_W), .UPDATE_ON_WRAP(1)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_ftw(ftw), .i_ftw_valid(ftw_valid),
    .o_ftw_ready(fready[1]), .i_poff(poff), .i_sync(sync), .o_saw(saw[1]),
    .o_wrap(wrap[1]), .o_valid(valid[1]), .i_ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by the rules for the current inputs, then one clock; sample at +1.
  task automatic tick();
    longint unsigned next;
    bit crossed, accepted, use_new;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_acc[m] = 0; m_ftw[m] = 0; m_pend[m] = 0; m_pv[m] = 0;
        m_saw[m] = '0; m_wrap[m] = 0; m_val[m] = 0;
      end else begin
        accepted = en && (!m_val[m] || ready);
        next     = m_acc[m] + m_ftw[m];
        crossed  = (next >= ACC_MOD);
        use_new  = m_pv[m] && (sync || (accepted && (m == 0 || crossed)));
        if (accepted) begin
          m_saw[m]  = 16'((m_acc[m] / 65536) + poff);
          m_wrap[m] = crossed && !sync;
          m_val[m]  = 1;
        end else if (m_val[m] && ready) begin
          m_val[m] = 0;
        end
        if (sync) m_acc[m] = 0;
        else if (accepted) m_acc[m] = next % ACC_MOD;
        if (use_new) begin
          m_ftw[m] = m_pend[m]; m_pv[m] = 0;
        end else if (ftw_valid && !m_pv[m]) begin
          m_pend[m] = ftw; m_pv[m] = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Load a tuning word into both instances while idle, applying it via a sync pulse.
  task automatic load_ftw(input logic [ACC_W-1:0] w);
    en = 0; ftw = w; ftw_valid = 1;
    tick();
    ftw_valid = 0; sync = 1;
    tick();
    sync = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (valid[m] !== 1'b0 || saw[m] !== 16'h0000 || wrap[m] !== 1'b0 || fready[m] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got v=%b saw=%h w=%b fr=%b, want 0 0000 0 0",
                 m, valid[m], saw[m], wrap[m], fready[m]);
      end
    end
    rst = 0;
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (fready[m] !== 1'b1 || valid[m] !== 1'b0) begin
        errors++;
        $display("FAIL reset_release[%0d]: got fr=%b v=%b, want 1 0", m, fready[m], valid[m]);
      end
    end
  endtask

  task automatic test_ramp();
    logic [15:0] exp_s;
    ready = 1; poff = 16'h0000;
    load_ftw(32'h0100_0000);
    en = 1;
    for (int k = 0; k < 258; k++) begin
      tick();
      exp_s = 16'(k * 256);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (valid[m] !== 1'b1 || saw[m] !== exp_s || wrap[m] !== (exp_s == 16'hFF00)) begin
          errors++;
          $display("FAIL ramp[%0d] k=%0d: got v=%b saw=%h w=%b, want 1 %h %b",
                   m, k, valid[m], saw[m], wrap[m], exp_s, exp_s == 16'hFF00);
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 300 && saw[1] !== 16'h0500; i++) tick();
    checks++;
    if (saw[1] !== 16'h0500) begin
      errors++;
      $display("FAIL stall_reach: got saw=%h, want 0500 within budget", saw[1]);
    end
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (valid[m] !== 1'b1 || saw[m] !== 16'h0500) begin
          errors++;
          $display("FAIL stall_hold[%0d] c=%0d: got v=%b saw=%h, want 1 0500", m, i, valid[m], saw[m]);
        end
      end
    end
    ready = 1;
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (valid[m] !== 1'b1 || saw[m] !== 16'h0600) begin
        errors++;
        $display("FAIL stall_resume[%0d]: got v=%b saw=%h, want 1 0600", m, valid[m], saw[m]);
      end
    end
  endtask

  task automatic test_wrap_update();
    logic [15:0] exp_n [3];
    logic [15:0] exp_w [3];
    logic [15:0] prev;
    bit found;
    exp_n = '{16'h8200, 16'h8300, 16'h8500};
    exp_w = '{16'h0000, 16'h0200, 16'h0400};
    for (int i = 0; i < 300 && saw[1] !== 16'h8000; i++) tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (saw[m] !== 16'h8000 || fready[m] !== 1'b1) begin
        errors++;
        $display("FAIL upd_start[%0d]: got saw=%h fr=%b, want 8000 1", m, saw[m], fready[m]);
      end
    end
    ftw = 32'h0200_0000; ftw_valid = 1;
    tick();
    ftw_valid = 0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (saw[m] !== 16'h8100 || fready[m] !== 1'b0) begin
        errors++;
        $display("FAIL upd_capture[%0d]: got saw=%h fr=%b, want 8100 0", m, saw[m], fready[m]);
      end
    end
    prev = 16'h8100;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i < 3) begin
        checks++;
        if (saw[0] !== exp_n[i] || fready[0] !== 1'b1) begin
          errors++;
          $display("FAIL upd_immediate i=%0d: got saw=%h fr=%b, want %h 1", i, saw[0], fready[0], exp_n[i]);
        end
      end
      if (wrap[1] === 1'b1) begin
        found = 1;
        break;
      end
      prev = prev + 16'h0100;
      checks++;
      if (saw[1] !== prev || fready[1] !== 1'b0) begin
        errors++;
        $display("FAIL upd_deferred i=%0d: got saw=%h fr=%b, want %h 0", i, saw[1], fready[1], prev);
      end
    end
    checks++;
    if (!found || saw[1] !== 16'hFF00 || fready[1] !== 1'b1) begin
      errors++;
      $display("FAIL upd_wrap: got found=%b saw=%h fr=%b, want 1 FF00 1", found, saw[1], fready[1]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (saw[1] !== exp_w[i] || wrap[1] !== 1'b0) begin
        errors++;
        $display("FAIL upd_newstep i=%0d: got saw=%h w=%b, want %h 0", i, saw[1], wrap[1], exp_w[i]);
      end
    end
  endtask

  task automatic test_poff();
    logic [15:0] exp_s [5];
    bit          exp_w [5];
    exp_s = '{16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h4000};
    exp_w = '{0, 0, 0, 1, 0};
    load_ftw(32'h4000_0000);
    poff = 16'h4000; en = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (saw[m] !== exp_s[i] || wrap[m] !== exp_w[i] || valid[m] !== 1'b1) begin
          errors++;
          $display("FAIL poff[%0d] i=%0d: got saw=%h w=%b v=%b, want %h %b 1",
                   m, i, saw[m], wrap[m], valid[m], exp_s[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_sync();
    poff = 16'h0000;
    load_ftw(32'h0100_0000);
    en = 1;
    for (int i = 0; i < 100 && saw[1] !== 16'h2E00; i++) tick();
    ftw = 32'h0300_0000; ftw_valid = 1;
    tick();
    ftw_valid = 0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (saw[m] !== 16'h2F00 || fready[m] !== 1'b0) begin
        errors++;
        $display("FAIL sync_pre[%0d]: got saw=%h fr=%b, want 2F00 0", m, saw[m], fready[m]);
      end
    end
    sync = 1;
    tick();
    sync = 0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (saw[m] !== 16'h3000 || wrap[m] !== 1'b0 || fready[m] !== 1'b1) begin
        errors++;
        $display("FAIL sync_hit[%0d]: got saw=%h w=%b fr=%b, want 3000 0 1", m, saw[m], wrap[m], fready[m]);
      end
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (saw[m] !== 16'h0000 || wrap[m] !== 1'b0) begin
        errors++;
        $display("FAIL sync_zero[%0d]: got saw=%h w=%b, want 0000 0", m, saw[m], wrap[m]);
      end
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (saw[m] !== 16'h0300) begin
        errors++;
        $display("FAIL sync_newftw[%0d]: got saw=%h, want 0300", m, saw[m]);
      end
    end
  endtask

  task automatic test_max_ftw();
    load_ftw(32'hFFFF_FFFF);
    en = 1;
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (saw[m] !== 16'h0000 || wrap[m] !== 1'b0) begin
        errors++;
        $display("FAIL maxftw_first[%0d]: got saw=%h w=%b, want 0000 0", m, saw[m], wrap[m]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (saw[m] !== 16'hFFFF || wrap[m] !== 1'b1) begin
          errors++;
          $display("FAIL maxftw_wrap[%0d] i=%0d: got saw=%h w=%b, want FFFF 1", m, i, saw[m], wrap[m]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    ready = 0; ftw = 32'h0500_0000; ftw_valid = 1;
    tick();
    ftw_valid = 0;
    rst = 1;
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (valid[m] !== 1'b0 || saw[m] !== 16'h0000 || fready[m] !== 1'b0) begin
        errors++;
        $display("FAIL midrst[%0d]: got v=%b saw=%h fr=%b, want 0 0000 0", m, valid[m], saw[m], fready[m]);
      end
    end
    rst = 0; poff = 16'h1234; en = 1; ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (valid[m] !== 1'b1 || saw[m] !== 16'h1234 || wrap[m] !== 1'b0 || fready[m] !== 1'b1) begin
          errors++;
          $display("FAIL midrst_after[%0d] i=%0d: got v=%b saw=%h w=%b fr=%b, want 1 1234 0 1",
                   m, i, valid[m], saw[m], wrap[m], fready[m]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      sync      = ($urandom_range(0, 39) == 0);
      en        = ($urandom_range(0, 9) < 8);
      ready     = ($urandom_range(0, 9) < 7);
      ftw_valid = ($urandom_range(0, 9) < 3);
      ftw       = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> 4);
      poff      = 16'($urandom);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (valid[m] !== m_val[m] || saw[m] !== m_saw[m] || wrap[m] !== m_wrap[m] ||
            fready[m] !== (!m_pv[m] && !rst)) begin
          errors++;
          $display("FAIL random[%0d] c=%0d: got v=%b saw=%h w=%b fr=%b, want %b %h %b %b",
                   m, c, valid[m], saw[m], wrap[m], fready[m],
                   m_val[m], m_saw[m], m_wrap[m], !m_pv[m] && !rst);
        end
      end
    end
    rst = 0; sync = 0; ftw_valid = 0;
  endtask

  initial begin
    rst = 1; en = 0; ftw = '0; ftw_valid = 0; poff = '0; sync = 0; ready = 1;
    for (int m = 0; m < 2; m++) begin
      m_acc[m] = 0; m_ftw[m] = 0; m_pend[m] = 0; m_pv[m] = 0;
      m_saw[m] = '0; m_wrap[m] = 0; m_val[m] = 0;
    end
    test_reset();
    test_ramp();
    test_stall();
    test_wrap_update();
    test_poff();
    test_sync();
    test_max_ftw();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
